// File: rtl/line_raster_multi_if.sv
// Line-command and pixel-beat channels of the multi-lane line rasterizer.
// Both channels are valid/ready: a transfer happens on a clock edge where valid
// and ready are both high; valid never waits on ready, and the sender holds
// payload stable from valid rising until that transfer.
interface line_raster_multi_if #(
  parameter int COORD_W = 13,
  parameter int LANES   = 2,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [COORD_W-1:0]   start_x;
  logic signed [COORD_W-1:0]   start_y;
  logic signed [COORD_W-1:0]   end_x;
  logic signed [COORD_W-1:0]   end_y;
  logic [COLOR_W-1:0]          color;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*COORD_W-1:0]    pix_x;
  logic [LANES*COORD_W-1:0]    pix_y;
  logic [LANES*ADDR_W-1:0]     pix_addr;
  logic [LANES-1:0]            pix_mask;
  logic [COLOR_W-1:0]          pix_color;
  logic                        out_last;

  modport master (
    output in_valid, start_x, start_y, end_x, end_y, color, out_ready,
    input  in_ready, out_valid, pix_x, pix_y, pix_addr, pix_mask, pix_color, out_last
  );

  modport slave (
    input  in_valid, start_x, start_y, end_x, end_y, color, out_ready,
    output in_ready, out_valid, pix_x, pix_y, pix_addr, pix_mask, pix_color, out_last
  );
endinterface

// File: rtl/line_raster_multi.sv
// Multi-lane Bresenham line rasterizer: one line in, beats of LANES pixels out.
// Optional SKIP_OFFSCREEN_EN swallows fully masked beats except the last one.
module line_raster_multi #(
  parameter int COORD_W  = 13,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int LANES    = 2,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  line_raster_multi_if.slave  bus,
  output logic                busy,
  output logic [1:0]          dbg_state
);
  localparam int W = COORD_W + 2;
  localparam logic signed [W-1:0] HALF_W = W'(SCREEN_W / 2);
  localparam logic signed [W-1:0] HALF_H = W'(SCREEN_H / 2);
  localparam logic signed [W-1:0] LIM_X  = W'(SCREEN_W);
  localparam logic signed [W-1:0] LIM_Y  = W'(SCREEN_H);
  localparam logic signed [W-1:0] ONE    = W'(1);
  localparam logic [ADDR_W-1:0]   ROW_A  = ADDR_W'(SCREEN_W);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, RUN = 2'd2} state_t;
  state_t state_q, state_d;

  logic signed [W-1:0] sx0_q, sy0_q, sx1_q, sy1_q;
  logic signed [W-1:0] dmaj_q, dmin_q;
  logic                xmaj_q, stxn_q, styn_q;
  logic signed [W-1:0] wx_q, wy_q, werr_q, wk_q;
  logic [LANES*COORD_W-1:0] px_q, py_q;
  logic [LANES*ADDR_W-1:0]  addr_q;
  logic [LANES-1:0]         mask_q;
  logic                     last_q;
  logic [COLOR_W-1:0]       color_q;

  logic in_ready_c, out_valid_c, advance, skip;

  // Setup: deltas in screen space, major axis, step directions
  logic signed [W-1:0] dx, dy, adx, ady, s_dmaj, s_dmin;
  logic                s_xmaj;
  always_comb begin
    dx     = sx1_q - sx0_q;
    dy     = sy1_q - sy0_q;
    adx    = dx[W-1] ? -dx : dx;
    ady    = dy[W-1] ? -dy : dy;
    s_xmaj = (adx >= ady);
    s_dmaj = s_xmaj ? adx : ady;
    s_dmin = s_xmaj ? ady : adx;
  end

  // The beat generator is fed straight from setup results in SETUP, then from the walker
  logic                c_setup, c_xmaj;
  logic signed [W-1:0] c_dmaj, c_dmin, c_x, c_y, c_err, c_k, c_stx, c_sty;
  always_comb begin
    c_setup = (state_q == SETUP);
    c_xmaj  = c_setup ? s_xmaj : xmaj_q;
    c_dmaj  = c_setup ? s_dmaj : dmaj_q;
    c_dmin  = c_setup ? s_dmin : dmin_q;
    c_x     = c_setup ? sx0_q : wx_q;
    c_y     = c_setup ? sy0_q : wy_q;
    c_err   = c_setup ? -s_dmaj : werr_q;
    c_k     = c_setup ? '0 : wk_q;
    c_stx   = (c_setup ? dx[W-1] : stxn_q) ? -ONE : ONE;
    c_sty   = (c_setup ? dy[W-1] : styn_q) ? -ONE : ONE;
  end

  // Error term e = r - 2*dmaj, where r is the remainder of (2k*dmin + dmaj) / (2*dmaj)
  logic [LANES*COORD_W-1:0] n_px, n_py;
  logic [LANES*ADDR_W-1:0]  n_addr;
  logic [LANES-1:0]         n_mask;
  logic                     n_last;
  logic signed [W-1:0]      t_x, t_y, t_e, n_wk;
  always_comb begin
    n_px   = '0;
    n_py   = '0;
    n_addr = '0;
    n_mask = '0;
    t_x    = c_x;
    t_y    = c_y;
    t_e    = c_err;
    for (int i = 0; i < LANES; i++) begin
      n_px[i*COORD_W +: COORD_W] = t_x[COORD_W-1:0];
      n_py[i*COORD_W +: COORD_W] = t_y[COORD_W-1:0];
      n_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(t_y) * ROW_A + ADDR_W'(t_x);
      n_mask[i] = ((c_k + W'(i)) <= c_dmaj) && (t_x >= 0) && (t_x < LIM_X) &&
                  (t_y >= 0) && (t_y < LIM_Y);
      t_e = t_e + c_dmin + c_dmin;
      if (c_xmaj) t_x = t_x + c_stx;
      else        t_y = t_y + c_sty;
      if (t_e >= 0) begin
        if (c_xmaj) t_y = t_y + c_sty;
        else        t_x = t_x + c_stx;
        t_e = t_e - c_dmaj - c_dmaj;
      end
    end
    n_last = (c_k + W'(LANES - 1)) >= c_dmaj;
    n_wk   = c_k + W'(LANES);
  end

`ifdef SKIP_OFFSCREEN_EN
  assign skip = (mask_q == '0) && !last_q;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = !rst;
        if (bus.in_valid && !rst) state_d = SETUP;
      end
      SETUP: state_d = RUN;
      RUN: begin
        out_valid_c = !skip;
        advance     = skip || bus.out_ready;
        if (advance && last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {sx0_q, sy0_q, sx1_q, sy1_q} <= '0;
      {dmaj_q, dmin_q, wx_q, wy_q, werr_q, wk_q} <= '0;
      {xmaj_q, stxn_q, styn_q} <= '0;
      px_q    <= '0;
      py_q    <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      color_q <= '0;
    end else begin
      if (state_q == IDLE && bus.in_valid) begin
        sx0_q   <= W'(bus.start_x) + HALF_W;
        sy0_q   <= HALF_H - W'(bus.start_y);
        sx1_q   <= W'(bus.end_x) + HALF_W;
        sy1_q   <= HALF_H - W'(bus.end_y);
        color_q <= bus.color;
      end
      if (c_setup) begin
        dmaj_q <= s_dmaj;
        dmin_q <= s_dmin;
        xmaj_q <= s_xmaj;
        stxn_q <= dx[W-1];
        styn_q <= dy[W-1];
      end
      if (c_setup || (advance && !last_q)) begin
        px_q   <= n_px;
        py_q   <= n_py;
        addr_q <= n_addr;
        mask_q <= n_mask;
        last_q <= n_last;
        wx_q   <= t_x;
        wy_q   <= t_y;
        werr_q <= t_e;
        wk_q   <= n_wk;
      end else if (advance) begin
        mask_q <= '0;
        last_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.pix_x     = px_q;
  assign bus.pix_y     = py_q;
  assign bus.pix_addr  = addr_q;
  assign bus.pix_mask  = mask_q;
  assign bus.pix_color = color_q;
  assign bus.out_last  = last_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;
endmodule
